// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - FSM states, default generator polynomials and encoder output helper
package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } vit_state_e;

    localparam int G0_DEF = 'o7;
    localparam int G1_DEF = 'o5;

    // Encoder register is {u, state}; the newest input bit sits at bit k-1.
    function automatic logic [1:0] vit_code(input int k, input int g0, input int g1,
                                            input int st, input logic u);
        int r;
        r = st | (int'(u) << (k - 1));
        return {^(r & g0), ^(r & g1)};
    endfunction

endpackage

// File: rtl/vit_acs_unit.sv
// rtl/vit_acs_unit.sv - one trellis state: normalised add-compare-select with saturation and survivor shift
module vit_acs_unit #(
    parameter int PM_W = 8,
    parameter int BM_W = 2,
    parameter int TB_D = 15
) (
    input  logic [PM_W-1:0] pm_a_i,
    input  logic [PM_W-1:0] pm_b_i,
    input  logic [PM_W-1:0] pm_min_i,
    input  logic [BM_W-1:0] bm_a_i,
    input  logic [BM_W-1:0] bm_b_i,
    input  logic [TB_D-1:0] surv_a_i,
    input  logic [TB_D-1:0] surv_b_i,
    input  logic            bit_i,
    output logic [PM_W-1:0] pm_o,
    output logic [TB_D-1:0] surv_o
);
    localparam int SW = PM_W + BM_W;
    localparam logic [SW-1:0] PM_MAX = {{BM_W{1'b0}}, {PM_W{1'b1}}};

    logic [SW-1:0] cand_a;
    logic [SW-1:0] cand_b;
    logic [SW-1:0] best;
    logic          sel_b;

    always_comb begin
        cand_a = SW'(pm_a_i) - SW'(pm_min_i) + SW'(bm_a_i);
        cand_b = SW'(pm_b_i) - SW'(pm_min_i) + SW'(bm_b_i);
        // Strict compare keeps the lower-index predecessor on a tie.
        sel_b  = cand_b < cand_a;
        best   = sel_b ? cand_b : cand_a;
        pm_o   = (best > PM_MAX) ? PM_MAX[PM_W-1:0] : best[PM_W-1:0];
        surv_o = {(sel_b ? surv_b_i[TB_D-2:0] : surv_a_i[TB_D-2:0]), bit_i};
    end

endmodule

// File: rtl/viterbi_stream_dec.sv
// rtl/viterbi_stream_dec.sv - streaming register-exchange Viterbi decoder; VITERBI_SOFT_EN selects soft-decision metrics
module viterbi_stream_dec
    import viterbi_pkg::*;
#(
    parameter int K    = 3,
    parameter int G0   = G0_DEF,
    parameter int G1   = G1_DEF,
    parameter int TB_D = 15,
    parameter int PM_W = 8,
`ifdef VITERBI_SOFT_EN
    parameter int SOFT_W = 3,
    localparam int SYM_W = 2 * SOFT_W,
    localparam int BM_W  = SOFT_W + 1
`else
    localparam int SYM_W = 2,
    localparam int BM_W  = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);
    localparam int NS = 1 << (K - 1);
    localparam int IW = K - 1;
    localparam int CW = $clog2(TB_D + 1);
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W - 1){1'b0}}};

    vit_state_e      state_q;
    logic [PM_W-1:0] pm_q   [NS];
    logic [TB_D-1:0] surv_q [NS];
    logic [CW-1:0]   fcnt_q;
    logic            out_valid_q;
    logic            out_bit_q;
    logic            out_last_q;

    logic [PM_W-1:0] pm_min;
    logic [PM_W-1:0] pm_acs   [NS];
    logic [TB_D-1:0] surv_acs [NS];
    logic [IW-1:0]   best_st;
    logic [CW-1:0]   fcnt_inc;
    logic            out_free;
    logic            accept;

    function automatic logic [BM_W-1:0] branch_metric(input logic [SYM_W-1:0] sym,
                                                      input logic [1:0] code);
`ifdef VITERBI_SOFT_EN
        logic [SOFT_W-1:0] r0, r1, d0, d1;
        r0 = sym[SYM_W-1:SOFT_W];
        r1 = sym[SOFT_W-1:0];
        d0 = code[1] ? ({SOFT_W{1'b1}} - r0) : r0;
        d1 = code[0] ? ({SOFT_W{1'b1}} - r1) : r1;
        return BM_W'(d0) + BM_W'(d1);
`else
        return BM_W'(sym[1] ^ code[1]) + BM_W'(sym[0] ^ code[0]);
`endif
    endfunction

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = rst && (state_q != ST_FLUSH) && out_free;
    assign accept    = in_valid && in_ready;
    assign fcnt_inc  = (fcnt_q == CW'(TB_D)) ? fcnt_q : fcnt_q + 1'b1;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = state_q != ST_IDLE;

    always_comb begin
        pm_min  = pm_q[0];
        best_st = '0;
        for (int s = 1; s < NS; s++) begin
            if (pm_q[s] < pm_min) pm_min = pm_q[s];
            if (pm_acs[s] < pm_acs[best_st]) best_st = IW'(s);
        end
    end

    // State n is reached from predecessors {n[K-3:0], b} with input bit n[K-2].
    for (genvar n = 0; n < NS; n++) begin : g_acs
        localparam int PA = (2 * n) % NS;
        localparam logic U = (n >= NS / 2);
        localparam logic [1:0] CA = vit_code(K, G0, G1, PA, U);
        localparam logic [1:0] CB = vit_code(K, G0, G1, PA + 1, U);

        vit_acs_unit #(
            .PM_W(PM_W),
            .BM_W(BM_W),
            .TB_D(TB_D)
        ) u_acs (
            .pm_a_i  (pm_q[PA]),
            .pm_b_i  (pm_q[PA+1]),
            .pm_min_i(pm_min),
            .bm_a_i  (branch_metric(in_sym, CA)),
            .bm_b_i  (branch_metric(in_sym, CB)),
            .surv_a_i(surv_q[PA]),
            .surv_b_i(surv_q[PA+1]),
            .bit_i   (U),
            .pm_o    (pm_acs[n]),
            .surv_o  (surv_acs[n])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            for (int s = 0; s < NS; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
                surv_q[s] <= '0;
            end
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (accept) begin
                        for (int s = 0; s < NS; s++) begin
                            pm_q[s]   <= pm_acs[s];
                            surv_q[s] <= surv_acs[s];
                        end
                        fcnt_q  <= fcnt_inc;
                        state_q <= in_last ? ST_FLUSH : ST_RUN;
                        // The closing symbol leaves its whole window to the terminated flush.
                        if (!in_last && fcnt_inc == CW'(TB_D)) begin
                            out_valid_q <= 1'b1;
                            out_bit_q   <= surv_acs[best_st][TB_D-1];
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q != '0 && out_free) begin
                        out_valid_q <= 1'b1;
                        out_bit_q   <= surv_q[0][fcnt_q - 1'b1];
                        out_last_q  <= (fcnt_q == CW'(1));
                        fcnt_q      <= fcnt_q - 1'b1;
                    end else if (fcnt_q == '0 && out_valid_q && out_ready && out_last_q) begin
                        state_q    <= ST_IDLE;
                        out_bit_q  <= 1'b0;
                        out_last_q <= 1'b0;
                        for (int s = 0; s < NS; s++) begin
                            pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
                            surv_q[s] <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_stream_dec.sv
// tb/tb_viterbi_stream_dec.sv - directed self-checking bench for viterbi_stream_dec
module tb_viterbi_stream_dec;
`ifdef VITERBI_SOFT_EN
    localparam int SYM_W = 6;
`else
    localparam int SYM_W = 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [SYM_W-1:0] in_sym = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_last;
    logic             busy;

    int               n_chk = 0;
    int               n_pass = 0;
    logic [SYM_W-1:0] tx_sym [64];
    logic             src [64];
    logic [1:0]       f1_code [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic             f1_bits [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int               n_out;
    int               last_pos;
    int               first_vld;
    int               stall_ok;
    logic [63:0]      rx_bits;
    logic             done;

    always #5 clk = ~clk;

    viterbi_stream_dec dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sym   (in_sym),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_last (out_last),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [SYM_W-1:0] mk_sym(input logic c0, input logic c1);
`ifdef VITERBI_SOFT_EN
        return {{3{c0}}, {3{c1}}};
`else
        return {c0, c1};
`endif
    endfunction

    task automatic encode(input int n);
        logic s1, s2, u;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            u = src[i];
            tx_sym[i] = mk_sym(u ^ s1 ^ s2, u ^ s2);
            s2 = s1;
            s1 = u;
        end
    endtask

    task automatic load_frame1();
        for (int i = 0; i < 6; i++) begin
            src[i]    = f1_bits[i];
            tx_sym[i] = mk_sym(f1_code[i][1], f1_code[i][0]);
        end
    endtask

    task automatic random_frame(input int n);
        for (int i = 0; i < n - 2; i++) src[i] = ($urandom_range(0, 1) != 0);
        src[n-2] = 1'b0;
        src[n-1] = 1'b0;
        encode(n);
    endtask

    function automatic logic [63:0] exp_bits(input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = src[i];
        return v;
    endfunction

    task automatic run_frame(input int n, input int stall_len, input int abort_at);
        int   idx = 0;
        int   stall_left = -1;
        logic held = 1'b0;
        n_out = 0; rx_bits = '0; last_pos = -1; first_vld = -1; stall_ok = 0; done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (abort_at >= 0 && idx == abort_at) break;
            in_valid = (idx < n);
            in_sym   = tx_sym[(idx < n) ? idx : 0];
            in_last  = (idx == n - 1);
            if (stall_left < 0 && stall_len > 0 && out_valid) begin
                stall_left = stall_len;
                held = out_bit;
            end
            out_ready = (stall_left <= 0);
            #1;
            if (first_vld < 0 && out_valid) first_vld = idx;
            if (stall_left > 0) begin
                if (out_valid && out_bit == held && !in_ready) stall_ok++;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                if (n_out < 64) rx_bits[n_out] = out_bit;
                if (out_last) begin
                    last_pos = n_out;
                    done = 1'b1;
                end
                n_out++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        #1;
        chk(tag, {busy, in_ready, out_valid}, 3'b010);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        load_frame1();
        run_frame(6, 0, -1);
        chk("f1_done", done, 1);
        chk("f1_bits", rx_bits, exp_bits(6));
        chk("f1_count", n_out, 6);
        chk("f1_last_pos", last_pos, 5);
        chk_idle("f1_idle");

        load_frame1();
`ifdef VITERBI_SOFT_EN
        tx_sym[2] = {3'd4, 3'd0};
`else
        tx_sym[1] = 2'b11;
`endif
        run_frame(6, 0, -1);
        chk("corr_bits", rx_bits, exp_bits(6));
        chk("corr_count", n_out, 6);
        chk("corr_last_pos", last_pos, 5);

        random_frame(40);
        run_frame(40, 0, -1);
        chk("r40_bits", rx_bits, exp_bits(40));
        chk("r40_count", n_out, 40);
        chk("r40_first_valid", first_vld, 15);
        chk("r40_last_pos", last_pos, 39);
        chk_idle("r40_idle");

        random_frame(20);
        run_frame(20, 5, -1);
        chk("stall_stable", stall_ok, 5);
        chk("stall_bits", rx_bits, exp_bits(20));
        chk("stall_count", n_out, 20);

        random_frame(12);
        run_frame(12, 0, 10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        load_frame1();
        run_frame(6, 0, -1);
        chk("after_rst_bits", rx_bits, exp_bits(6));
        chk("after_rst_count", n_out, 6);

        src[0] = 1'b0;
        tx_sym[0] = mk_sym(1'b0, 1'b0);
        run_frame(1, 0, -1);
        chk("one_bits", rx_bits, exp_bits(1));
        chk("one_count", n_out, 1);
        chk("one_last_pos", last_pos, 0);
        chk_idle("one_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
